// File: rtl/sext_arb_if.sv
// Handshake bundle between two immediate requesters, the shared sign-extend
// unit and its result consumer.
// master = requester/consumer side, slave = the arbiter itself.
interface sext_arb_if #(
  parameter int IMM_W = 12,
  parameter int OUT_W = 32
);
  // requester 0
  logic             req0_valid;
  logic [IMM_W-1:0] req0_imm;
  logic             req0_neg;
  logic             req0_ready;
  // requester 1
  logic             req1_valid;
  logic [IMM_W-1:0] req1_imm;
  logic             req1_neg;
  logic             req1_ready;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_src;
  logic             busy;

  modport master (
    output req0_valid, req0_imm, req0_neg,
    input  req0_ready,
    output req1_valid, req1_imm, req1_neg,
    input  req1_ready,
    output out_ready,
    input  out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req0_valid, req0_imm, req0_neg,
    output req0_ready,
    input  req1_valid, req1_imm, req1_neg,
    output req1_ready,
    input  out_ready,
    output out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/sext_arb.sv
// Two-requester round-robin arbiter in front of one sign-extend (optionally negate) datapath.
// Latency: grant in cycle N, out_valid in N+2, next grant possible in N+3 with out_ready high.
// Backpressure: result is held in DONE until out_ready; requesters see ready only in IDLE.
// Optional negation is built only when macro SEXT_ARB_NEG_EN is defined.
module sext_arb #(
  parameter int IMM_W = 12,
  parameter int OUT_W = 32
) (
  input logic       clk,
  input logic       rst,
  sext_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             last;        // requester served most recently (1 => req1)
  logic [IMM_W-1:0] imm_q;
  logic             src_q;
  logic             gnt0;
  logic             gnt1;
  logic             grant;
  logic [OUT_W-1:0] ext;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_src_q;
  logic             busy_q;

`ifdef SEXT_ARB_NEG_EN
  logic             neg_q;
`else
  // Negate requests have no effect in this build.
  logic             unused_neg;
  assign unused_neg = bus.req0_neg ^ bus.req1_neg;
`endif

  // Round-robin pick: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if ((state == IDLE) && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign grant          = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Shared datapath: sign-extend the captured immediate, optionally two's-complement it.
  always_comb begin
    ext = {{(OUT_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
`ifdef SEXT_ARB_NEG_EN
    if (neg_q) begin
      // Wraps modulo 2^OUT_W; -(most negative IMM) fits because OUT_W > IMM_W.
      ext = (~ext) + {{(OUT_W-1){1'b0}}, 1'b1};
    end
`endif
  end

  // Control FSM with registered result, source and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 1'b1;       // makes requester 0 first priority
      imm_q       <= '0;
      src_q       <= 1'b0;
`ifdef SEXT_ARB_NEG_EN
      neg_q       <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            imm_q  <= gnt1 ? bus.req1_imm : bus.req0_imm;
`ifdef SEXT_ARB_NEG_EN
            neg_q  <= gnt1 ? bus.req1_neg : bus.req0_neg;
`endif
            src_q  <= gnt1;
            last   <= gnt1;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          out_data_q  <= ext;
          out_src_q   <= src_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          // out_data/out_src are left untouched so they stay stable while stalled.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = busy_q;

  // Protocol invariants: one ready at most, none during reset, result held while stalled.
  a_ready_onehot : assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));
  a_ready_in_rst : assert property (@(posedge clk) rst |-> !(bus.req0_ready || bus.req1_ready));
  a_hold_stalled : assert property (@(posedge clk) disable iff (rst)
                     (bus.out_valid && !bus.out_ready) |=>
                     (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_src)));

endmodule

// File: tb/tb_sext_arb.sv
// Scoreboard bench for sext_arb: directed cases then randomized traffic against a reference model.
module tb_sext_arb;
  localparam int IMM_W = 12;
  localparam int OUT_W = 32;
`ifdef SEXT_ARB_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  sext_arb_if #(.IMM_W(IMM_W), .OUT_W(OUT_W)) bus ();
  sext_arb #(.IMM_W(IMM_W), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        src;
    int          cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          out_count = 0;
  int          expect_grant_cyc = -1;
  exp_t        exp_q[$];
  logic        gnt_log[$];
  logic        m_last = 1'b1;
  logic        m_busy = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] last_data = '0;
  logic        last_src = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference: value of the immediate as a signed integer, optionally negated, taken mod 2^32.
  function automatic logic [31:0] model(input logic [11:0] imm, input logic neg);
    longint v;
    logic [63:0] r;
    v = (imm >= 12'h800) ? longint'(imm) - 4096 : longint'(imm);
    if (neg && NEG_EN) v = -v;
    r = 64'(v);
    return r[31:0];
  endfunction

  // Monitor/scoreboard: records grants as expected results, checks outputs when presented.
  always @(negedge clk) begin
    logic nb;
    logic src;
    exp_t e;
    cyc++;
    if (rst) begin
      check("ready_in_reset", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      exp_q.delete();
      m_last = 1'b1;
      m_busy = 1'b0;
      prev_stall = 1'b0;
      expect_grant_cyc = -1;
    end else begin
      nb = m_busy;
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
      if (m_busy) check("ready_while_busy", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
      if (bus.out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_without_grant: out_valid=1 data=0x%08h, required no result pending", bus.out_data);
        end else begin
          e = exp_q[0];
          if (!prev_stall) check("out_latency", 32'(cyc - e.cyc), 32'd2);
          check("out_data", bus.out_data, e.data);
          check("out_src", 32'(bus.out_src), 32'(e.src));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            out_count++;
            last_data = bus.out_data;
            last_src = bus.out_src;
            nb = 1'b0;
            expect_grant_cyc = cyc + 1;
          end
        end
      end
      if ((cyc == expect_grant_cyc) && (bus.req0_valid || bus.req1_valid))
        check("grant_after_done", 32'(bus.req0_ready | bus.req1_ready), 32'd1);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        src = bus.req1_valid && bus.req1_ready;
        if (bus.req0_valid && bus.req1_valid) check("rr_grant", 32'(src), 32'(!m_last));
        e.data = src ? model(bus.req1_imm, bus.req1_neg) : model(bus.req0_imm, bus.req0_neg);
        e.src = src;
        e.cyc = cyc;
        exp_q.push_back(e);
        gnt_log.push_back(src);
        m_last = src;
        nb = 1'b1;
      end
      m_busy = nb;
      prev_stall = bus.out_valid && !bus.out_ready;
    end
  end

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  // One transfer from a single requester, checked against a literal expected result.
  task automatic send(input logic src, input logic [11:0] imm, input logic neg,
                      input logic [31:0] exp_data, input string name);
    int start;
    int n;
    start = out_count;
    n = 0;
    @(posedge clk); #1;
    if (src) begin
      bus.req1_valid = 1'b1; bus.req1_imm = imm; bus.req1_neg = neg;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_imm = imm; bus.req0_neg = neg;
    end
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(src ? bus.req1_ready : bus.req0_ready) && n < 20);
    if (n >= 20) timeout({name, "_grant"});
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n = 0;
    while (out_count == start && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    if (out_count == start) timeout({name, "_result"});
    else begin
      check(name, last_data, exp_data);
      check({name, "_src"}, 32'(last_src), 32'(src));
    end
  endtask

  function automatic logic [11:0] rand_imm();
    case ($urandom_range(0, 5))
      0: return 12'h000;
      1: return 12'h800;
      2: return 12'h7FF;
      3: return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    int base;
    int n;
    logic hs0;
    logic hs1;
    bus.req0_valid = 1'b1; bus.req0_imm = 12'h001; bus.req0_neg = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_imm = 12'h002; bus.req1_neg = 1'b0;
    bus.out_ready  = 1'b1;
    rst = 1'b1;

    // Reset state, with both requesters valid to show ready stays low.
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_out_src", 32'(bus.out_src), 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic extension cases.
    send(1'b0, 12'd10,  1'b0, 32'h0000000A, "req0_imm10");
    send(1'b1, 12'hFFB, 1'b0, 32'hFFFFFFFB, "req1_minus5");
    send(1'b1, 12'd1337, 1'b1, NEG_EN ? 32'hFFFFFAC7 : 32'h00000539, "neg_1337");

    // Both valid continuously: grants must alternate starting with requester 0.
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_imm = 12'd12;  bus.req0_neg = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_imm = 12'hFF4; bus.req1_neg = 1'b0;
    base = gnt_log.size();
    n = 0;
    while (gnt_log.size() < base + 4 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (gnt_log.size() < base + 4) timeout("alternate");
    else for (int i = 0; i < 4; i++) check("alternate_src", 32'(gnt_log[base+i]), 32'(i % 2));
    drain();

    // Stall in DONE for 5 cycles with the other requester waiting.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_imm = 12'h123; bus.req0_neg = 1'b0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.req0_ready && n < 20);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_imm = 12'h007; bus.req1_neg = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (!bus.out_valid) timeout("stall_out_valid");
    base = gnt_log.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_data", bus.out_data, 32'h00000123);
      check("stall_readies", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      check("stall_busy", 32'(bus.busy), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    n = 0;
    while (gnt_log.size() == base && n < 10) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    if (gnt_log.size() == base) timeout("grant_after_stall");
    else check("grant_after_stall_src", 32'(gnt_log[base]), 32'd1);
    drain();

    // Boundary values.
    send(1'b0, 12'h81D, 1'b1, NEG_EN ? 32'h000007E3 : 32'hFFFFF81D, "neg_81d");
    send(1'b0, 12'h800, 1'b1, NEG_EN ? 32'h00000800 : 32'hFFFFF800, "neg_most_negative");
    send(1'b1, 12'h000, 1'b1, 32'h00000000, "neg_zero");
    send(1'b1, 12'h7FF, 1'b0, 32'h000007FF, "max_positive");

    // Reset during EXEC abandons the result and restores requester-0 priority.
    send(1'b0, 12'h055, 1'b0, 32'h00000055, "pre_reset");
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_imm = 12'h0AA; bus.req0_neg = 1'b0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.req0_ready && n < 20);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("no_out_after_rst", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_imm = 12'h001;
    bus.req1_valid = 1'b1; bus.req1_imm = 12'h002;
    base = gnt_log.size();
    n = 0;
    while (gnt_log.size() == base && n < 10) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (gnt_log.size() == base) timeout("grant_after_rst");
    else check("grant_after_rst_src", 32'(gnt_log[base]), 32'd0);
    drain();

    // Randomized traffic with occasional withdrawals and consumer stalls.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); #1;
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (hs0 || !bus.req0_valid) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_imm   = rand_imm();
        bus.req0_neg   = 1'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        bus.req0_valid = 1'b0;
      end
      if (hs1 || !bus.req1_valid) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_imm   = rand_imm();
        bus.req1_neg   = 1'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        bus.req1_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sext_arb.md
SEXT_ARB -- requirements
Module: sext_arb

Interface
REQ-001 Parameter IMM_W, default 12, immediate width in bits; SHALL be less than OUT_W.
REQ-002 Parameter OUT_W, default 32, extended result width in bits.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0_valid  input  1  requester 0 has an immediate pending.
REQ-006 req0_imm  input  IMM_W  requester 0 immediate, two's complement.
REQ-007 req0_neg  input  1  requester 0 asks for the negated result.
REQ-008 req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-009 req1_valid, req1_imm, req1_neg, req1_ready SHALL be identical to REQ-005..REQ-008 for requester 1.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  OUT_W  sign-extended, optionally negated, result.
REQ-013 out_src  output  1  index of the requester that produced out_data.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL share one extend/negate datapath between two requesters, using an FSM with states IDLE, EXEC and DONE.
REQ-016 IDLE: if any reqN_valid is high, the block SHALL grant one requester, assert only that requester's reqN_ready combinationally in that cycle, capture imm/neg/src, and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-017 reqN_ready SHALL be low in EXEC and DONE, and SHALL never be high for both requesters in the same cycle.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; with one valid, grant that one; the last-served pointer SHALL update only on a grant.
REQ-019 EXEC: the block SHALL register ext = imm sign-extended to OUT_W (upper OUT_W-IMM_W bits equal to imm[IMM_W-1]) and go to DONE.
REQ-020 If neg is captured high, the registered value SHALL be the two's complement negation of ext, modulo 2^OUT_W.
REQ-021 DONE: out_valid SHALL be high and out_data/out_src SHALL be stable until out_ready is sampled high; the block SHALL then go to IDLE.
REQ-022 Latency: for a handshake in cycle N with out_ready held high, out_valid SHALL rise in cycle N+2 and the next grant SHALL be possible in cycle N+3.
REQ-023 Throughput: the block SHALL accept at most one transfer per 3 cycles.
REQ-024 Boundary values: imm = 0 with neg high SHALL give 0; imm = most-negative with neg high SHALL give +2^(IMM_W-1) (0x00000800 at defaults); the result SHALL never saturate.
REQ-025 A requester that drops valid before being granted SHALL be ignored without error.

Reset
REQ-026 With rst high at a clock edge, the FSM SHALL go to IDLE, the pointer SHALL select requester 0 as first priority, and out_valid, out_data, out_src and busy SHALL be 0.
REQ-027 Reset in EXEC or DONE SHALL abandon the transaction; no out_valid SHALL appear for it.
REQ-028 reqN_ready SHALL be low during any cycle in which rst is high.

Configuration
REQ-029 Macro SEXT_ARB_NEG_EN, when defined, SHALL enable REQ-020.
REQ-030 When SEXT_ARB_NEG_EN is undefined, reqN_neg SHALL be ignored, out_data SHALL always be the plain sign extension, and no negation logic SHALL be built.

Verification
REQ-031 Reset, then req0 imm=10, neg=0 -> out_data=0x0000000A, out_src=0, out_valid 2 cycles after the handshake.
REQ-032 req1 imm=0xFFB (-5), neg=0 -> 0xFFFFFFFB; with the macro defined, imm=1337, neg=1 -> 0xFFFFFAC7.
REQ-033 Both valid continuously with imm=12 and imm=-12 -> grants alternate 0,1,0,1 and results alternate 0x0000000C / 0xFFFFFFF4.
REQ-034 out_ready held low 5 cycles in DONE -> out_data stable, both readies low, busy high; the release returns the FSM to IDLE.
REQ-035 imm=0x81D (-2019), neg=1 -> 0x000007E3; imm=0x800, neg=1 -> 0x00000800; without the macro, neg=1 on 0x81D -> 0xFFFFF81D.
REQ-036 rst pulsed in EXEC -> no out_valid appears; the next grant with both valid goes to requester 0.
